// File: rtl/stream_sort_if.sv
// Valid/ready stream pair for stream_sort: unsorted input frame in, sorted (largest first) frame out.
interface stream_sort_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_sort.sv
// Frame sorter: insertion-sorts up to DEPTH elements on arrival, then drains them largest first.
// Optional macro STREAM_SORT_DEDUP_EN drops elements equal to an already stored value.
module stream_sort #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  stream_sort_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] s      [DEPTH];
  logic [WIDTH-1:0] s_next [DEPTH];
  logic [CW-1:0]    ins_pos;
  logic             store;
  logic             accept;
  logic             pop;

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = (state == DRAIN) ? s[0] : '0;
  assign bus.out_last  = (state == DRAIN) && (count == CW'(1));

  assign accept = bus.in_valid && (state == LOAD);
  assign pop    = bus.out_ready && (state == DRAIN);

  // Slots are non-increasing, so the insertion point is the first valid slot smaller than the new value.
  always_comb begin
    ins_pos = count;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count && s[i] < bus.in_data) ins_pos = CW'(i);
    end
  end

`ifdef STREAM_SORT_DEDUP_EN
  always_comb begin
    store = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && s[i] == bus.in_data) store = 1'b0;
    end
  end
`else
  assign store = 1'b1;
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    for (int i = 0; i < DEPTH; i++) s_next[i] = s[i];

    if (accept) begin
      if (store) begin
        count_next = count + CW'(1);
        s_next[0]  = (ins_pos == '0) ? bus.in_data : s[0];
        for (int i = 1; i < DEPTH; i++) begin
          if (CW'(i) == ins_pos)
            s_next[i] = bus.in_data;
          else if (CW'(i) > ins_pos && CW'(i) <= count)
            s_next[i] = s[i-1];
        end
      end
      if (bus.in_last || count_next == CW'(DEPTH)) state_next = DRAIN;
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) s_next[i] = s[i+1];
      s_next[DEPTH-1] = '0;
      count_next = count - CW'(1);
      if (count == CW'(1)) state_next = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      for (int i = 0; i < DEPTH; i++) s[i] <= s_next[i];
    end
  end
endmodule

// File: tb/tb_stream_sort.sv
// Directed bench for stream_sort (WIDTH=4, DEPTH=4) with hand-computed sorted outputs.
module tb_stream_sort;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  stream_sort_if #(.WIDTH(4)) bus ();

  stream_sort #(.WIDTH(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one element for exactly one clock, then samples 1 ns after the edge.
  task automatic apply_stimulus(input logic [3:0] v, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [3:0] v, input logic last);
    check_output({tag, "_valid"}, bus.out_valid, 1);
    check_output({tag, "_data"}, bus.out_data, v);
    check_output({tag, "_last"}, bus.out_last, last);
    check_output({tag, "_in_ready"}, bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    check_output({tag, "_idle_valid"}, bus.out_valid, 0);
    check_output({tag, "_idle_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_out_data", bus.out_data, 0);
    check_output("rst_out_last", bus.out_last, 0);
    check_output("rst_in_ready", bus.in_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Auto-close at DEPTH with a duplicate 9.
    apply_stimulus(4'd3, 1'b0);
    apply_stimulus(4'd9, 1'b0);
    apply_stimulus(4'd1, 1'b0);
    check_output("t1_not_closed", bus.out_valid, 0);
    apply_stimulus(4'd9, 1'b0);
    expect_beat("t1_b0", 4'd9, 1'b0);
    expect_beat("t1_b1", 4'd9, 1'b0);
    expect_beat("t1_b2", 4'd3, 1'b0);
    expect_beat("t1_b3", 4'd1, 1'b1);
    expect_idle("t1");

    // Explicit in_last closes a short frame; first output one cycle after the closing accept.
    apply_stimulus(4'd5, 1'b0);
    check_output("t2_wait_valid", bus.out_valid, 0);
    apply_stimulus(4'd2, 1'b1);
    expect_beat("t2_b0", 4'd5, 1'b0);
    expect_beat("t2_b1", 4'd2, 1'b1);
    expect_idle("t2");

    // Extreme values are real data, not empty markers.
    apply_stimulus(4'd15, 1'b0);
    apply_stimulus(4'd0, 1'b0);
    apply_stimulus(4'd15, 1'b0);
    apply_stimulus(4'd0, 1'b0);
    expect_beat("t3_b0", 4'd15, 1'b0);
    expect_beat("t3_b1", 4'd15, 1'b0);
    expect_beat("t3_b2", 4'd0, 1'b0);
    expect_beat("t3_b3", 4'd0, 1'b1);
    expect_idle("t3");

    // Ascending arrival forces every insert to the front; then back-pressure mid-drain with input noise.
    apply_stimulus(4'd1, 1'b0);
    apply_stimulus(4'd2, 1'b0);
    apply_stimulus(4'd4, 1'b0);
    apply_stimulus(4'd8, 1'b0);
    expect_beat("t4_b0", 4'd8, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd15;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_output("t4_hold_data", bus.out_data, 4);
      check_output("t4_hold_last", bus.out_last, 0);
      check_output("t4_hold_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    expect_beat("t4_b1", 4'd4, 1'b0);
    expect_beat("t4_b2", 4'd2, 1'b0);
    expect_beat("t4_b3", 4'd1, 1'b1);
    expect_idle("t4");

    // Mid-frame reset discards the partial frame.
    apply_stimulus(4'd12, 1'b0);
    apply_stimulus(4'd13, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("t5_rst_valid", bus.out_valid, 0);
    check_output("t5_rst_data", bus.out_data, 0);
    check_output("t5_rst_last", bus.out_last, 0);
    check_output("t5_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(4'd7, 1'b0);
    apply_stimulus(4'd6, 1'b0);
    apply_stimulus(4'd5, 1'b0);
    apply_stimulus(4'd4, 1'b0);
    expect_beat("t5_b0", 4'd7, 1'b0);
    expect_beat("t5_b1", 4'd6, 1'b0);
    expect_beat("t5_b2", 4'd5, 1'b0);
    expect_beat("t5_b3", 4'd4, 1'b1);
    expect_idle("t5");

`ifdef STREAM_SORT_DEDUP_EN
    apply_stimulus(4'd6, 1'b0);
    apply_stimulus(4'd6, 1'b0);
    apply_stimulus(4'd3, 1'b0);
    apply_stimulus(4'd6, 1'b0);
    apply_stimulus(4'd2, 1'b0);
    check_output("t6_not_closed", bus.out_valid, 0);
    apply_stimulus(4'd1, 1'b0);
    expect_beat("t6_b0", 4'd6, 1'b0);
    expect_beat("t6_b1", 4'd3, 1'b0);
    expect_beat("t6_b2", 4'd2, 1'b0);
    expect_beat("t6_b3", 4'd1, 1'b1);
    expect_idle("t6");
`else
    apply_stimulus(4'd6, 1'b0);
    apply_stimulus(4'd6, 1'b0);
    apply_stimulus(4'd3, 1'b0);
    apply_stimulus(4'd6, 1'b0);
    expect_beat("t6_b0", 4'd6, 1'b0);
    expect_beat("t6_b1", 4'd6, 1'b0);
    expect_beat("t6_b2", 4'd6, 1'b0);
    expect_beat("t6_b3", 4'd3, 1'b1);
    expect_idle("t6");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
